sdram_arbit: RTL and testbench

- Central arbiter of the SDRAM controller. It receives service requests from the init, auto-refresh, write and read sub-modules.
- It grants exactly one requester at a time via one-cycle enable pulses, and multiplexes the granted sub-module's command, address, bank and data onto the SDRAM pins.
- It is the grant side of the ref_req/ref_en/flag_ref_end handshake, and of the matching write and read handshakes.

---
 rtl/sdram_arbit.sv | 274 +++++++++++++++++++++++++++
 tb/tb_sdram_arbit.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit.sv
// -----------------------------------------------------------------------------
// sdram_arbit
//
// Central arbiter of the SDRAM controller. After the init sub-module reports
// completion, it grants the SDRAM pins to one of the auto-refresh, write or
// read sub-modules at a time. Refresh has strict priority. Write and read
// alternate when both request. The granted sub-module's command, address,
// bank and write data are multiplexed onto the pins. A watchdog returns the
// bus to arbitration if a granted sub-module never raises its end flag. The
// sticky err_timeout output records that event.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   flag_init_end                   init done; leaves IDLE on its first 1
//   init_cmd/init_addr              init sub-module pin values (owned in IDLE)
//   ref_req/ref_en/flag_ref_end     refresh request / grant pulse / done
//   aref_cmd/aref_addr              refresh pin values
//   wr_req/wr_en/flag_wr_end        write request / grant pulse / done
//   wr_cmd/wr_addr/wr_ba            write pin values
//   wr_dq/wr_dq_oe                  write data and its drive enable
//   rd_req/rd_en/flag_rd_end        read request / grant pulse / done
//   rd_cmd/rd_addr/rd_ba            read pin values
//   sdram_cmd/addr/ba               muxed SDRAM command, address, bank
//   sdram_dq_out/sdram_dq_oe        data to pad and pad output enable
//   err_timeout                     sticky watchdog flag
// -----------------------------------------------------------------------------
module sdram_arbit #(
    parameter logic [3:0] NOP     = 4'b0111,
    parameter int         TIMEOUT = 1023,
    parameter int         TO_W    = 10
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        flag_init_end,
    input  logic [3:0]  init_cmd,
    input  logic [12:0] init_addr,

    input  logic        ref_req,
    input  logic        flag_ref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [12:0] aref_addr,
    output logic        ref_en,

    input  logic        wr_req,
    input  logic        flag_wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [12:0] wr_addr,
    input  logic [1:0]  wr_ba,
    input  logic [15:0] wr_dq,
    input  logic        wr_dq_oe,
    output logic        wr_en,

    input  logic        rd_req,
    input  logic        flag_rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [12:0] rd_addr,
    input  logic [1:0]  rd_ba,
    output logic        rd_en,

    output logic [3:0]  sdram_cmd,
    output logic [12:0] sdram_addr,
    output logic [1:0]  sdram_ba,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

    state_t          state_r;
    state_t          state_s;
    logic            grant_ref_s;
    logic            grant_wr_s;
    logic            grant_rd_s;
    logic            timeout_s;
    logic            busy_s;
    logic            last_wr_r;
    logic [TO_W-1:0] to_cnt_r;
    logic            ref_en_r;
    logic            wr_en_r;
    logic            rd_en_r;
    logic            err_timeout_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: arbitration in ARBIT, end-flag or watchdog exit from
    // the granted states. The grant strobes feed the registered enables so
    // each pulse lines up with the first cycle of its state.
    always_comb begin
        state_s     = state_r;
        grant_ref_s = 1'b0;
        grant_wr_s  = 1'b0;
        grant_rd_s  = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (flag_init_end) begin
                    state_s = ST_ARBIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARBIT: begin
                if (ref_req) begin
                    state_s     = ST_AREF;
                    grant_ref_s = 1'b1;
                end else if (wr_req && (!rd_req || !last_wr_r)) begin
                    // Write wins when alone, or when both request and the
                    // previous data grant went to read.
                    state_s    = ST_WRITE;
                    grant_wr_s = 1'b1;
                end else if (rd_req) begin
                    state_s    = ST_READ;
                    grant_rd_s = 1'b1;
                end else begin
                    state_s = ST_ARBIT;
                end
            end
            ST_AREF: begin
                if (flag_ref_end) begin
                    state_s = ST_ARBIT;
                end else if (to_cnt_r == TO_MAX) begin
                    state_s   = ST_ARBIT;
                    timeout_s = 1'b1;
                end else begin
                    state_s = ST_AREF;
                end
            end
            ST_WRITE: begin
                if (flag_wr_end) begin
                    state_s = ST_ARBIT;
                end else if (to_cnt_r == TO_MAX) begin
                    state_s   = ST_ARBIT;
                    timeout_s = 1'b1;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_READ: begin
                if (flag_rd_end) begin
                    state_s = ST_ARBIT;
                end else if (to_cnt_r == TO_MAX) begin
                    state_s   = ST_ARBIT;
                    timeout_s = 1'b1;
                end else begin
                    state_s = ST_READ;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output mux: the owner of the current state drives the SDRAM pins.
    always_comb begin
        sdram_cmd    = NOP;
        sdram_addr   = 13'd0;
        sdram_ba     = 2'd0;
        sdram_dq_oe  = 1'b0;
        sdram_dq_out = wr_dq;
        case (state_r)
            ST_IDLE: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_ARBIT: begin
                sdram_cmd  = NOP;
                sdram_addr = 13'd0;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd   = wr_cmd;
                sdram_addr  = wr_addr;
                sdram_ba    = wr_ba;
                sdram_dq_oe = wr_dq_oe;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_ba   = rd_ba;
            end
            default: begin
                sdram_cmd = NOP;
            end
        endcase
    end

    // A sub-module owns the bus in any of the three granted states.
    always_comb begin
        if ((state_r == ST_AREF) || (state_r == ST_WRITE) || (state_r == ST_READ)) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

    // Grant pulses: high for exactly the first cycle of the granted state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_en_r <= 1'b0;
            wr_en_r  <= 1'b0;
            rd_en_r  <= 1'b0;
        end else begin
            ref_en_r <= grant_ref_s;
            wr_en_r  <= grant_wr_s;
            rd_en_r  <= grant_rd_s;
        end
    end

    // Round-robin memory: remembers whether the last data grant was a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr_r <= 1'b0;
        end else if (grant_wr_s) begin
            last_wr_r <= 1'b1;
        end else if (grant_rd_s) begin
            last_wr_r <= 1'b0;
        end else begin
            last_wr_r <= last_wr_r;
        end
    end

    // Watchdog counter. Every granted state is entered from ARBIT, so holding
    // zero there is what clears it on entry. It saturates at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= '0;
        end else if (!busy_s) begin
            to_cnt_r <= '0;
        end else if (to_cnt_r != TO_MAX) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Sticky timeout flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout_r <= 1'b0;
        end else if (timeout_s) begin
            err_timeout_r <= 1'b1;
        end else begin
            err_timeout_r <= err_timeout_r;
        end
    end

    assign ref_en      = ref_en_r;
    assign wr_en       = wr_en_r;
    assign rd_en       = rd_en_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_sdram_arbit.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbit
//
// Self-checking bench for sdram_arbit. A transaction-level reference model
// tracks which sub-module owns the bus, how long it has held it, the
// round-robin preference and the sticky error. From that it predicts every
// output each cycle. Scenario tasks drive directed and random stimulus and
// compare the DUT against the model.
// -----------------------------------------------------------------------------
module tb_sdram_arbit;

    localparam int TIMEOUT = 1023;

    localparam int O_IDLE = 0;
    localparam int O_ARB  = 1;
    localparam int O_REF  = 2;
    localparam int O_WR   = 3;
    localparam int O_RD   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flag_init_end;
    logic [3:0]  init_cmd;
    logic [12:0] init_addr;
    logic        ref_req, flag_ref_end;
    logic [3:0]  aref_cmd;
    logic [12:0] aref_addr;
    logic        ref_en;
    logic        wr_req, flag_wr_end;
    logic [3:0]  wr_cmd;
    logic [12:0] wr_addr;
    logic [1:0]  wr_ba;
    logic [15:0] wr_dq;
    logic        wr_dq_oe;
    logic        wr_en;
    logic        rd_req, flag_rd_end;
    logic [3:0]  rd_cmd;
    logic [12:0] rd_addr;
    logic [1:0]  rd_ba;
    logic        rd_en;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_ba;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;
    logic        err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_owner;
    int m_cyc;
    bit m_last_wr;
    bit m_err;
    bit m_ref_en, m_wr_en, m_rd_en;

    logic [39:0] obs_vec;
    assign obs_vec = {ref_en, wr_en, rd_en, err_timeout, sdram_cmd, sdram_addr,
                      sdram_ba, sdram_dq_oe, sdram_dq_out};

    sdram_arbit dut (
        .clk(clk), .rst_n(rst_n),
        .flag_init_end(flag_init_end), .init_cmd(init_cmd), .init_addr(init_addr),
        .ref_req(ref_req), .flag_ref_end(flag_ref_end), .aref_cmd(aref_cmd),
        .aref_addr(aref_addr), .ref_en(ref_en),
        .wr_req(wr_req), .flag_wr_end(flag_wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
        .wr_ba(wr_ba), .wr_dq(wr_dq), .wr_dq_oe(wr_dq_oe), .wr_en(wr_en),
        .rd_req(rd_req), .flag_rd_end(flag_rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
        .rd_ba(rd_ba), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner   = O_IDLE;
        m_cyc     = 0;
        m_last_wr = 1'b0;
        m_err     = 1'b0;
        m_ref_en  = 1'b0;
        m_wr_en   = 1'b0;
        m_rd_en   = 1'b0;
    endtask

    // Advance the model by one clock using the inputs the DUT samples.
    task automatic model_step();
        bit done;
        m_ref_en = 1'b0;
        m_wr_en  = 1'b0;
        m_rd_en  = 1'b0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_owner == O_IDLE) begin
            if (flag_init_end) m_owner = O_ARB;
        end else if (m_owner == O_ARB) begin
            m_cyc = 0;
            if (ref_req) begin
                m_owner = O_REF; m_ref_en = 1'b1;
            end else if (wr_req && !(rd_req && m_last_wr)) begin
                m_owner = O_WR; m_wr_en = 1'b1; m_last_wr = 1'b1;
            end else if (rd_req) begin
                m_owner = O_RD; m_rd_en = 1'b1; m_last_wr = 1'b0;
            end
        end else begin
            done = (m_owner == O_REF) ? flag_ref_end :
                   (m_owner == O_WR)  ? flag_wr_end  : flag_rd_end;
            if (done) begin
                m_owner = O_ARB;
            end else if (m_cyc == TIMEOUT) begin
                m_owner = O_ARB;
                m_err   = 1'b1;
            end else begin
                m_cyc = m_cyc + 1;
            end
        end
    endtask

    function automatic logic [39:0] exp_vec();
        logic [3:0]  c;
        logic [12:0] a;
        logic [1:0]  b;
        logic        oe;
        c = 4'b0111; a = 13'd0; b = 2'd0; oe = 1'b0;
        case (m_owner)
            O_IDLE:  begin c = init_cmd; a = init_addr; end
            O_REF:   begin c = aref_cmd; a = aref_addr; end
            O_WR:    begin c = wr_cmd;   a = wr_addr; b = wr_ba; oe = wr_dq_oe; end
            O_RD:    begin c = rd_cmd;   a = rd_addr; b = rd_ba; end
            default: begin end
        endcase
        return {m_ref_en, m_wr_en, m_rd_en, m_err, c, a, b, oe, wr_dq};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic rand_data();
        init_cmd  = 4'($urandom); init_addr = 13'($urandom);
        aref_cmd  = 4'($urandom); aref_addr = 13'($urandom);
        wr_cmd    = 4'($urandom); wr_addr   = 13'($urandom); wr_ba = 2'($urandom);
        wr_dq     = 16'($urandom); wr_dq_oe = 1'($urandom);
        rd_cmd    = 4'($urandom); rd_addr   = 13'($urandom); rd_ba = 2'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flag_init_end = 1'b0;
        ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        flag_ref_end = 1'b0; flag_wr_end = 1'b0; flag_rd_end = 1'b0;
        rand_data();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        if (obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs_vec, exp_vec());
        end
        n_checks++;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_data();
            ref_req = 1'($urandom); wr_req = 1'($urandom); rd_req = 1'($urandom);
            tick();
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL idle_hold cycle %0d: got %h expected %h", i, obs_vec, exp_vec());
            end
            n_checks++;
        end
        ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        flag_init_end = 1'b1;
        tick();
        flag_init_end = 1'b0;
        if (sdram_cmd !== 4'b0111 || sdram_addr !== 13'd0) begin
            n_fail++;
            $display("FAIL init_to_arbit: got cmd %b addr %h expected cmd 0111 addr 0",
                     sdram_cmd, sdram_addr);
        end
        n_checks++;
    endtask

    task automatic test_priority();
        ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        tick();
        if (ref_en !== 1'b1 || wr_en !== 1'b0 || rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL ref_priority: got en %b%b%b expected 100", ref_en, wr_en, rd_en);
        end
        n_checks++;
        ref_req = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL in_aref cycle %0d: got %h expected %h", i, obs_vec, exp_vec());
            end
            n_checks++;
        end
        flag_ref_end = 1'b1;
        tick();
        flag_ref_end = 1'b0;
        if (obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL aref_exit: got %h expected %h", obs_vec, exp_vec());
        end
        n_checks++;
        tick();
        if (wr_en !== 1'b1 || rd_en !== 1'b0 || ref_en !== 1'b0) begin
            n_fail++;
            $display("FAIL first_wr_grant: got en %b%b%b expected 010", ref_en, wr_en, rd_en);
        end
        n_checks++;
        repeat (3) tick();
        flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
        tick();
        if (rd_en !== 1'b1 || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_rd_grant: got wr_en %b rd_en %b expected 0 1", wr_en, rd_en);
        end
        n_checks++;
        flag_rd_end = 1'b1;
        tick();
        flag_rd_end = 1'b0;
        if (obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL rd_exit: got %h expected %h", obs_vec, exp_vec());
        end
        n_checks++;
    endtask

    task automatic test_round_robin();
        int seq[$];
        int k;
        int budget;
        wr_req = 1'b1; rd_req = 1'b1;
        k = $urandom_range(1, 4);
        budget = 0;
        while ((seq.size() < 6 || m_owner != O_ARB) && budget < 200) begin
            rand_data();
            tick();
            budget++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL rr_cycle %0d: got %h expected %h", budget, obs_vec, exp_vec());
            end
            n_checks++;
            if (int'(ref_en) + int'(wr_en) + int'(rd_en) > 1) begin
                n_fail++;
                $display("FAIL rr_onehot: got en %b%b%b expected at most one", ref_en, wr_en, rd_en);
            end
            n_checks++;
            if (wr_en) seq.push_back(1);
            if (rd_en) seq.push_back(0);
            if (seq.size() >= 6) begin wr_req = 1'b0; rd_req = 1'b0; end
            flag_wr_end = (m_owner == O_WR && m_cyc >= k);
            flag_rd_end = (m_owner == O_RD && m_cyc >= k);
            if (flag_wr_end || flag_rd_end) k = $urandom_range(1, 4);
        end
        flag_wr_end = 1'b0; flag_rd_end = 1'b0;
        if (budget >= 200) begin
            n_fail++;
            $display("FAIL rr_budget: got %0d grants expected 6 within 200 cycles", seq.size());
        end
        n_checks++;
        for (int i = 0; i < 6; i++) begin
            if (i >= seq.size() || seq[i] !== ((i % 2) == 0 ? 1 : 0)) begin
                n_fail++;
                $display("FAIL rr_order grant %0d: got %s expected %s", i,
                         (i < seq.size()) ? (seq[i] == 1 ? "W" : "R") : "none",
                         ((i % 2) == 0) ? "W" : "R");
            end
            n_checks++;
        end
    endtask

    task automatic test_mux();
        wr_cmd = 4'b0100; wr_dq = 16'hA5A5; wr_dq_oe = 1'b1;
        wr_req = 1'b1; rd_req = 1'b0;
        tick();
        wr_req = 1'b0;
        if (sdram_cmd !== 4'b0100 || sdram_dq_out !== 16'hA5A5 || sdram_dq_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL write_mux: got cmd %b dq %h oe %b expected 0100 a5a5 1",
                     sdram_cmd, sdram_dq_out, sdram_dq_oe);
        end
        n_checks++;
        if (sdram_addr !== wr_addr || sdram_ba !== wr_ba) begin
            n_fail++;
            $display("FAIL write_addr: got %h/%h expected %h/%h", sdram_addr, sdram_ba, wr_addr, wr_ba);
        end
        n_checks++;
        flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        if (sdram_dq_oe !== 1'b0 || sdram_cmd !== rd_cmd) begin
            n_fail++;
            $display("FAIL read_mux: got oe %b cmd %b expected 0 %b", sdram_dq_oe, sdram_cmd, rd_cmd);
        end
        n_checks++;
        flag_rd_end = 1'b1;
        tick();
        flag_rd_end = 1'b0;
    endtask

    task automatic test_timeout_error();
        int budget;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        budget = 0;
        while (m_owner == O_RD && budget < 1100) begin
            tick();
            budget++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL to_wait cycle %0d: got %h expected %h", budget, obs_vec, exp_vec());
            end
            n_checks++;
        end
        if (err_timeout !== 1'b1 || sdram_cmd !== 4'b0111 || budget != TIMEOUT + 1) begin
            n_fail++;
            $display("FAIL timeout_fire: got err %b cmd %b after %0d cycles expected 1 0111 after %0d",
                     err_timeout, sdram_cmd, budget, TIMEOUT + 1);
        end
        n_checks++;
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
        tick();
        if (err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: got %b expected 1", err_timeout);
        end
        n_checks++;
    endtask

    task automatic test_reset_mid();
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        if (obs_vec !== exp_vec() || err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h expected %h", obs_vec, exp_vec());
        end
        n_checks++;
        #2;
        rst_n = 1'b1;
        ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL post_reset_idle %0d: got %h expected %h", i, obs_vec, exp_vec());
            end
            n_checks++;
        end
        ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        flag_init_end = 1'b1;
        tick();
        flag_init_end = 1'b0;
        if (obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL reinit: got %h expected %h", obs_vec, exp_vec());
        end
        n_checks++;
    endtask

    task automatic test_timeout_flag();
        int budget;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        budget = 0;
        while (m_owner == O_RD && budget < 1100) begin
            tick();
            budget++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL flag_wait cycle %0d: got %h expected %h", budget, obs_vec, exp_vec());
            end
            n_checks++;
            flag_rd_end = (m_owner == O_RD && m_cyc == TIMEOUT);
        end
        flag_rd_end = 1'b0;
        if (err_timeout !== 1'b0 || sdram_cmd !== 4'b0111 || budget != TIMEOUT + 1) begin
            n_fail++;
            $display("FAIL flag_at_limit: got err %b cmd %b after %0d cycles expected 0 0111 after %0d",
                     err_timeout, sdram_cmd, budget, TIMEOUT + 1);
        end
        n_checks++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rand_data();
            ref_req       = ($urandom_range(0, 7) == 0);
            wr_req        = ($urandom_range(0, 2) == 0);
            rd_req        = ($urandom_range(0, 2) == 0);
            flag_ref_end  = ($urandom_range(0, 5) == 0);
            flag_wr_end   = ($urandom_range(0, 5) == 0);
            flag_rd_end   = ($urandom_range(0, 5) == 0);
            flag_init_end = 1'($urandom);
            tick();
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h expected %h", i, obs_vec, exp_vec());
            end
            n_checks++;
        end
        ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        flag_ref_end = 1'b0; flag_wr_end = 1'b0; flag_rd_end = 1'b0;
        flag_init_end = 1'b0;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_round_robin();
        test_mux();
        test_timeout_error();
        test_reset_mid();
        test_timeout_flag();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
